fp16_add_sched: RTL and testbench
=================================

Name: fp16_add_sched

Overview:
- Round-robin scheduler that shares one combinational fp16 adder (float_adder) between NUM_REQ requesters in the accelerator datapath.
- Each requester issues an operand pair plus an add/sub flag over a valid/ready handshake.
- The block drives the shared adder, registers the adder result, and returns it tagged with the requester id over a valid/ready response channel.
- Sustains one operation per cycle when the response channel is not stalled.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must equal clog2(NUM_REQ), with a minimum of 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_a  in  16*NUM_REQ  fp16 operand A; requester i uses bits [16i+15:16i]
- req_b  in  16*NUM_REQ  fp16 operand B, packed the same way
- req_sub  in  NUM_REQ  1 = compute A-B, 0 = compute A+B
- add_in1  out  16  operand 1 to the shared float_adder
- add_in2  out  16  operand 2 to the shared float_adder
- add_result  in  16  combinational float_adder sum
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  16  fp16 result
- rsp_id  out  ID_W  id of the requester that issued the operation
- op_cnt  out  16  count of completed responses; wraps at 0xFFFF->0

Behaviour:
- Reset (rst=1 at a clk edge): rsp_valid=0, rsp_data=0, rsp_id=0, op_cnt=0, rr_ptr=0. req_ready is all zeros during the reset cycle. An operation in flight is discarded without a response.
- can_issue = !rsp_valid | rsp_ready. This gives the output register pass-through on drain and allows back-to-back issue.
- Arbitration (combinational): search req_valid starting at index rr_ptr, ascending with wrap-around. The first set bit is the winner g. req_ready[g] = can_issue & !rst. All other req_ready bits are 0. No winner means no issue.
- Adder drive:
  - add_in1 = req_a[g].
  - add_in2 = {req_b[g][15]^req_sub[g], req_b[g][14:0]}, i.e. subtraction is done by flipping the sign of B.
  - With no winner, add_in1 = add_in2 = 0.
- Issue at a clk edge (winner exists and can_issue): rsp_data <= add_result, rsp_id <= g, rsp_valid <= 1, rr_ptr <= (g+1) mod NUM_REQ.
- Latency: the operation is accepted at edge N and its response is visible from edge N onward, valid in cycle N+1. Throughput is 1 per cycle.
- Drain with no new issue (rsp_valid & rsp_ready and no winner): rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Stall (rsp_valid & !rsp_ready): rsp_valid, rsp_data and rsp_id are held stable. All req_ready bits are 0. rr_ptr is unchanged.
- op_cnt increments by 1 on every edge where rsp_valid & rsp_ready, including a simultaneous drain and issue. It wraps from 0xFFFF to 0.
- rr_ptr changes only on issue. A requester that drops req_valid before it is granted loses no state.
- Requester protocol: a requester keeps req_a, req_b and req_sub stable while req_valid is high and not yet accepted. The block never samples operands on non-grant cycles.
- Single requester active: it is granted every cycle it is valid and not stalled.
- All requesters valid: grants rotate 0,1,2,3,0,... with no requester starved. The worst-case wait is NUM_REQ-1 grants.
- Adder special values (inf/NaN/subnormal) pass through unmodified. The scheduler does no arithmetic beyond the sign flip.

Test Plan:
- Reset then single op: req 0 issues a=0x3C00 (1.0), b=0x4000 (2.0), sub=0 -> one cycle later rsp_valid=1, rsp_data=0x4200 (3.0), rsp_id=0; after rsp_ready, op_cnt=1.
- Subtract: req 2 issues a=0x4200 (3.0), b=0x3C00 (1.0), sub=1 -> add_in2=0xBC00, rsp_data=0x4000, rsp_id=2.
- Fairness: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles; op_cnt=6 after 6 responses.
- Backpressure: rsp_ready=0 for 3 cycles while req 1 and req 3 are valid -> rsp_data/rsp_id stable, req_ready=0, rr_ptr frozen; on release, req 1 is granted first, then req 3 the next cycle.
- Drain with concurrent issue: rsp_valid=1, rsp_ready=1, req 0 valid with a=b=0x3800 (0.5) -> new rsp_data=0x3C00 in the same edge, no bubble, op_cnt +1.
- Reset mid-stream: rst=1 while rsp_valid=1 and requesters valid -> next cycle rsp_valid=0, op_cnt=0, req_ready=0 during reset; after deassert, the first grant goes to req 0.

Source files
------------

// File: rtl/fp16_add_sched.sv
// Round-robin scheduler that time-shares one combinational fp16 adder between
// NUM_REQ requesters and returns each registered sum tagged with its requester id.
module fp16_add_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_sub,
    output logic [15:0]            add_in1,
    output logic [15:0]            add_in2,
    input  logic [15:0]            add_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            op_cnt
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
    logic [15:0]     op_cnt_q,    op_cnt_d;
    logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic grant_found;
    int   grant_idx;
    int   cand;
    logic can_issue;
    logic issue;

    // The output register may be refilled in the same edge it is drained.
    assign can_issue = !rsp_valid_q || rsp_ready;
    assign issue     = grant_found && can_issue && !rst;

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        add_in1   = '0;
        add_in2   = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
        end
        // Subtraction is addition with B's sign bit inverted.
        if (grant_found) begin
            add_in1 = req_a[grant_idx*16 +: 16];
            add_in2 = {req_b[grant_idx*16 + 15] ^ req_sub[grant_idx],
                       req_b[grant_idx*16 +: 15]};
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        op_cnt_d    = op_cnt_q + 16'(rsp_valid_q && rsp_ready);
        if (issue) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = add_result;
            rsp_id_d    = ID_W'(grant_idx);
            rr_ptr_d    = (grant_idx == NUM_REQ - 1) ? '0 : ID_W'(grant_idx + 1);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            op_cnt_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            op_cnt_q    <= op_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_fp16_add_sched.sv
// Self-checking bench for fp16_add_sched: the bench plays the shared adder and
// tracks expected grants/responses with a transaction-level reference model.
module tb_fp16_add_sched;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_a;
    logic [16*N-1:0]   req_b;
    logic [N-1:0]      req_sub;
    logic [15:0]       add_in1;
    logic [15:0]       add_in2;
    logic [15:0]       add_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [ID_W-1:0]   rsp_id;
    logic [15:0]       op_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr;
    logic        m_valid;
    logic [15:0] m_data;
    int          m_id;
    logic [15:0] m_cnt;
    logic [N-1:0] last_ready;

    fp16_add_sched #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .add_in1(add_in1), .add_in2(add_in2), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:10]);
        if (e == 0) begin
            m = real'(h[9:0]) / 1024.0;
            e = 1;
        end else begin
            m = 1.0 + real'(h[9:0]) / 1024.0;
        end
        while (e > 15) begin m = m * 2.0; e--; end
        while (e < 15) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  a;
        int   e;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        if (e > 30) return {s, 15'h7C00};
        if (a < 1.0) return {s, 5'd0, 10'($rtoi(a * 1024.0))};
        return {s, 5'(e), 10'($rtoi((a - 1.0) * 1024.0))};
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] y);
        return r2h(h2r(x) + h2r(y));
    endfunction

    function automatic logic [15:0] rand_fp();
        return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
    endfunction

    // Stand-in for the shared combinational float_adder.
    always_comb add_result = fp_add(add_in1, add_in2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model mid-cycle, then advance one edge.
    task automatic step();
        int           w;
        bit           iss;
        logic [N-1:0] er;
        logic [15:0]  e1, e2;
        @(negedge clk);
        w = -1;
        for (int d = 0; d < N; d++) begin
            if (w < 0 && req_valid[(m_ptr + d) % N]) w = (m_ptr + d) % N;
        end
        iss = (w >= 0) && (!m_valid || rsp_ready) && !rst;
        er  = iss ? (N'(1) << w) : '0;
        e1  = (w >= 0) ? req_a[w*16 +: 16] : 16'h0000;
        e2  = (w >= 0) ? (req_b[w*16 +: 16] ^ {req_sub[w], 15'h0}) : 16'h0000;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_data",  32'(rsp_data),  32'(m_data));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("op_cnt",    32'(op_cnt),    32'(m_cnt));
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("add_in1",   32'(add_in1),   32'(e1));
        chk("add_in2",   32'(add_in2),   32'(e2));
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_cnt = '0; m_ptr = 0;
        end else begin
            if (m_valid && rsp_ready) m_cnt = m_cnt + 16'd1;
            if (iss) begin
                m_valid = 1'b1;
                m_data  = fp_add(e1, e2);
                m_id    = w;
                m_ptr   = (w + 1) % N;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
        last_ready = er;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          seq [6] = '{0, 1, 2, 3, 0, 1};
        logic [15:0] base;
        logic [15:0] held;

        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_cnt = '0; last_ready = '0;
        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();

        // Single add from requester 0
        rst = 1'b0; req_valid = 4'b0001;
        req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4000; req_sub[0] = 1'b0;
        step();
        chk("single_data", 32'(rsp_data), 32'h4200);
        chk("single_id",   32'(rsp_id),   32'h0);
        req_valid = '0; rsp_ready = 1'b1;
        step();
        chk("single_cnt",  32'(op_cnt),   32'h1);

        // Subtract from requester 2
        req_valid = 4'b0100;
        req_a[47:32] = 16'h4200; req_b[47:32] = 16'h3C00; req_sub[2] = 1'b1;
        #1;
        chk("sub_add_in2", 32'(add_in2), 32'hBC00);
        step();
        chk("sub_data", 32'(rsp_data), 32'h4000);
        chk("sub_id",   32'(rsp_id),   32'h2);

        // Park the pointer at 0 through requester 3, then all requesters contend
        for (int i = 0; i < N; i++) begin
            req_a[i*16 +: 16] = rand_fp(); req_b[i*16 +: 16] = rand_fp(); req_sub[i] = 1'($urandom);
        end
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        base = m_cnt;
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fair_id", 32'(rsp_id), 32'(seq[k]));
        end
        req_valid = '0;
        step();
        chk("fair_cnt", 32'(op_cnt), 32'(base + 16'd6));

        // Backpressure with requesters 1 and 3 pending
        req_valid = 4'b1000;
        step();
        held = rsp_data;
        rsp_ready = 1'b0; req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_ready", 32'(req_ready), 32'h0);
            chk("stall_id",    32'(rsp_id),    32'h3);
            chk("stall_data",  32'(rsp_data),  32'(held));
        end
        rsp_ready = 1'b1;
        step();
        chk("release_first",  32'(rsp_id), 32'h1);
        step();
        chk("release_second", 32'(rsp_id), 32'h3);

        // Drain and issue in the same edge
        req_valid = 4'b0001; req_a[15:0] = 16'h3800; req_b[15:0] = 16'h3800; req_sub[0] = 1'b0;
        base = m_cnt;
        step();
        chk("drain_data",  32'(rsp_data),  32'h3C00);
        chk("drain_valid", 32'(rsp_valid), 32'h1);
        chk("drain_cnt",   32'(op_cnt),    32'(base + 16'd1));

        // Reset mid-stream
        req_valid = '1; rst = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        step();
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_cnt",   32'(op_cnt),    32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_id",    32'(rsp_id),    32'h0);
        chk("post_rst_valid", 32'(rsp_valid), 32'h1);

        // Random traffic; operands only change while idle or just accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_ready[i]) begin
                    req_a[i*16 +: 16] = rand_fp();
                    req_b[i*16 +: 16] = rand_fp();
                    req_sub[i]        = 1'($urandom);
                end
                req_valid[i] = ($urandom_range(0, 9) < 6);
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
